operand_builder: RTL
====================

Name: operand_builder

Overview:
- Sits directly downstream of the keypad scanner/decoder and consumes its read_input/key_read handshake and decoded key fields (digit, operator code, equal flag).
- Assembles signed 16-bit operands from decimal digit entry and latches the operator.
- On equals, issues a start/done transaction to the arithmetic unit and exposes the current entry or result as a display value.
- Supports result chaining and an error state on overflow.

Parameters:
- WIDTH, 16, operand/result width (two's complement).
- MAX_MAG, 32767, largest accepted entry magnitude.

Ports:
- clk  in  1  system clock
- nRST  in  1  reset, asynchronous, active-low
- read_input  in  1  key available from the keypad stage (level, held until key release)
- key_read  out  1  one-cycle acknowledge of an accepted key
- keypad_input  in  4  digit 0-9
- operator_input  in  3  000 none, 001 sign toggle, 010 add, 011 sub, 100 mul, 101-111 reserved
- equal_input  in  1  equals key
- op_a  out  WIDTH  left operand to the arithmetic unit
- op_b  out  WIDTH  right operand
- op_code  out  3  latched operator (010/011/100)
- calc_start  out  1  one-cycle start pulse
- calc_done  in  1  arithmetic-unit completion pulse
- calc_result  in  WIDTH  signed result, valid with calc_done
- calc_overflow  in  1  overflow flag, valid with calc_done
- display_value  out  WIDTH  signed value for the display stage
- error  out  1  high while in the ERROR state

Behaviour:
- Reset values:
  - key_read=0, calc_start=0, op_a=0, op_b=0, op_code=000, display_value=0, error=0.
  - Internal entry magnitude=0, neg=0, armed=1, state ENTER_A.
- Key acceptance:
  - A key is accepted on the clock edge where read_input=1, armed=1, and the state is not CALC.
  - key_read is high for exactly the next cycle.
  - armed clears on acceptance and sets again only on a cycle with read_input=0.
  - A held key is therefore consumed once.
  - The entry register, state and display_value update on the same edge that raises key_read (1-cycle latency).
- Key classification, in priority order:
  1. equal_input=1 -> equals.
  2. operator_input!=000 -> operator.
  3. Otherwise -> digit.
- Reserved operator codes (101-111) are accepted (acknowledged) but have no effect.
- Digit:
  - Candidate = mag*10 + d, computed as (mag<<3)+(mag<<1)+d at 19-bit width.
  - If candidate > MAX_MAG, the digit is acknowledged and ignored; otherwise mag = candidate.
- Sign toggle (001): neg ^= 1. Signed entry = neg ? -mag : mag.
- States:
  - ENTER_A:
    - digit/sign update the entry.
    - add/sub/mul: op_a = signed entry, op_code = op, clear entry -> ENTER_B.
    - equals: ignored.
  - ENTER_B:
    - digit/sign update the entry.
    - add/sub/mul: replaces op_code, entry kept.
    - equals: op_b = signed entry (0 if no digits) -> CALC, calc_start=1 for one cycle.
  - CALC:
    - No keys accepted; the pending key stays pending.
    - op_a, op_b and op_code are held stable.
    - On calc_done with calc_overflow=0: display_value = calc_result, op_a = calc_result -> SHOW_RESULT.
    - On calc_done with calc_overflow=1 -> ERROR.
  - SHOW_RESULT:
    - digit: entry = d, neg=0 -> ENTER_A.
    - add/sub/mul: op_a keeps the result, op_code = op, entry cleared -> ENTER_B.
    - sign: entry = |result|, neg = !(result<0) -> ENTER_A.
    - equals: ignored.
  - ERROR:
    - error=1, display_value=0.
    - Any accepted key clears everything (op_a=op_b=0, op_code=000, entry 0) -> ENTER_A.
    - That key has no other effect.
- display_value:
  - ENTER_A and ENTER_B: signed entry, updated combinationally from the registers.
  - SHOW_RESULT: the result.
- Simultaneous calc_done and read_input in CALC: the result is captured; the key is accepted no earlier than the next cycle.
- calc_done outside CALC: ignored.
- Reset mid-CALC: immediate return to the reset values; the arithmetic unit shares nRST.

Decomposition:
- Shared package calc_pkg:
  - op-code localparams OP_NONE=000, OP_NEG=001, OP_ADD=010, OP_SUB=011, OP_MUL=100.
  - state enum ENTER_A, ENTER_B, CALC, SHOW_RESULT, ERROR.
  - WIDTH default.
- One sub-module: entry_accumulator.
  - Contents: mag/neg registers, x10+d with limit check, clear/load ports, signed output.

Test Plan:
- Digits 1,2,3, each with read_input held 5 cycles -> exactly three key_read pulses; display_value=123.
- Key sequence 5, add(010), 7, equals; arithmetic-unit model returns 12 after 3 cycles -> one calc_start pulse with op_a=5, op_b=7, op_code=010 held until calc_done; display_value=12; state SHOW_RESULT.
- Digits 3,2,7,6,7,9 -> 5th digit gives 32767, 6th digit ignored but acknowledged; sign toggle -> display_value=-32767 (16'h8001).
- Key sequence 9, mul, 9, equals; model returns calc_overflow=1 -> error=1, display_value=0; next digit key 4 -> error=0, display_value=0, state ENTER_A; following digit 4 -> display_value=4.
- Chaining, after result 12: sub, 2, equals -> calc_start with op_a=12, op_b=2, op_code=011.
- read_input asserted during CALC -> key_read stays 0 until after calc_done; nRST pulsed mid-CALC -> all outputs at their reset values.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operator codes, control states and defaults.
package calc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        CALC,
        SHOW_RESULT,
        ERROR
    } state_e;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/entry_accumulator.sv
// Decimal entry register: magnitude built digit by digit with a ceiling, plus a sign flag.
module entry_accumulator
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_MAG = 32767
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_mag_i,
    input  logic             load_neg_i,
    input  logic             digit_i,
    input  logic [3:0]       digit_val_i,
    input  logic             toggle_i,
    output logic [WIDTH-1:0] value_o
);

    localparam int unsigned CandW = WIDTH + 3;

    logic [WIDTH-1:0] mag_q, mag_d;
    logic             neg_q, neg_d;
    logic [CandW-1:0] mag_ext, cand;

    always_comb begin
        mag_ext = CandW'(mag_q);
        // mag*10 + d without a multiplier
        cand    = (mag_ext << 3) + (mag_ext << 1) + CandW'(digit_val_i);
        mag_d   = mag_q;
        neg_d   = neg_q;
        if (clear_i) begin
            mag_d = '0;
            neg_d = 1'b0;
        end else if (load_i) begin
            mag_d = load_mag_i;
            neg_d = load_neg_i;
        end else begin
            if (digit_i && (cand <= CandW'(MAX_MAG))) begin
                mag_d = cand[WIDTH-1:0];
            end
            if (toggle_i) begin
                neg_d = ~neg_q;
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mag_q <= '0;
            neg_q <= 1'b0;
        end else begin
            mag_q <= mag_d;
            neg_q <= neg_d;
        end
    end

    assign value_o = neg_q ? (-mag_q) : mag_q;

endmodule

// File: rtl/operand_builder.sv
// Turns accepted keypad keys into operands/operator, runs one arithmetic transaction per equals
// and tracks result chaining and overflow error.
module operand_builder
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_MAG = 32767
) (
    input  logic             clk,
    input  logic             nRST,
    input  logic             read_input,
    output logic             key_read,
    input  logic [3:0]       keypad_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [2:0]       op_code,
    output logic             calc_start,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_result,
    input  logic             calc_overflow,
    output logic [WIDTH-1:0] display_value,
    output logic             error
);

    state_e           state_q;
    logic             armed_q;
    logic             key_read_q;
    logic             calc_start_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [2:0]       op_code_q;

    logic             accept;
    logic             is_eq, is_arith, is_neg, is_digit, in_entry;
    logic             ent_clear, ent_load, ent_digit, ent_toggle, ent_load_neg;
    logic [WIDTH-1:0] ent_load_mag, entry_value, result_abs;

    // CALC holds off acceptance so a pending key waits for the result
    assign accept = read_input && armed_q && (state_q != CALC);

    always_comb begin
        is_eq    = equal_input;
        is_arith = !equal_input && is_arith_op(operator_input);
        is_neg   = !equal_input && (operator_input == OP_NEG);
        is_digit = !equal_input && (operator_input == OP_NONE);
        in_entry = (state_q == ENTER_A) || (state_q == ENTER_B);
    end

    // In SHOW_RESULT op_a_q already carries the result
    assign result_abs = op_a_q[WIDTH-1] ? (-op_a_q) : op_a_q;

    always_comb begin
        ent_clear    = accept && ((state_q == ERROR) ||
                       (is_arith && ((state_q == ENTER_A) || (state_q == SHOW_RESULT))));
        ent_load     = accept && (state_q == SHOW_RESULT) && (is_digit || is_neg);
        ent_digit    = accept && in_entry && is_digit;
        ent_toggle   = accept && in_entry && is_neg;
        ent_load_mag = is_digit ? WIDTH'(keypad_input) : result_abs;
        ent_load_neg = is_digit ? 1'b0 : !op_a_q[WIDTH-1];
    end

    entry_accumulator #(
        .WIDTH   (WIDTH),
        .MAX_MAG (MAX_MAG)
    ) u_entry (
        .clk         (clk),
        .nRST        (nRST),
        .clear_i     (ent_clear),
        .load_i      (ent_load),
        .load_mag_i  (ent_load_mag),
        .load_neg_i  (ent_load_neg),
        .digit_i     (ent_digit),
        .digit_val_i (keypad_input),
        .toggle_i    (ent_toggle),
        .value_o     (entry_value)
    );

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ENTER_A;
            armed_q      <= 1'b1;
            key_read_q   <= 1'b0;
            calc_start_q <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= OP_NONE;
        end else begin
            key_read_q   <= accept;
            calc_start_q <= 1'b0;
            if (accept) begin
                armed_q <= 1'b0;
            end else if (!read_input) begin
                armed_q <= 1'b1;
            end

            unique case (state_q)
                ENTER_A: begin
                    if (accept && is_arith) begin
                        op_a_q    <= entry_value;
                        op_code_q <= operator_input;
                        state_q   <= ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (accept && is_arith) begin
                        op_code_q <= operator_input;
                    end else if (accept && is_eq) begin
                        op_b_q       <= entry_value;
                        calc_start_q <= 1'b1;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    if (calc_done) begin
                        if (calc_overflow) begin
                            state_q <= ERROR;
                        end else begin
                            op_a_q  <= calc_result;
                            state_q <= SHOW_RESULT;
                        end
                    end
                end
                SHOW_RESULT: begin
                    if (accept) begin
                        if (is_digit || is_neg) begin
                            state_q <= ENTER_A;
                        end else if (is_arith) begin
                            op_code_q <= operator_input;
                            state_q   <= ENTER_B;
                        end
                    end
                end
                ERROR: begin
                    if (accept) begin
                        op_a_q    <= '0;
                        op_b_q    <= '0;
                        op_code_q <= OP_NONE;
                        state_q   <= ENTER_A;
                    end
                end
                default: state_q <= ENTER_A;
            endcase
        end
    end

    always_comb begin
        unique case (state_q)
            ENTER_A, ENTER_B: display_value = entry_value;
            CALC:             display_value = op_b_q;
            SHOW_RESULT:      display_value = op_a_q;
            default:          display_value = '0;
        endcase
    end

    assign key_read   = key_read_q;
    assign calc_start = calc_start_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_code    = op_code_q;
    assign error      = (state_q == ERROR);

endmodule
